// File: rtl/copro_axil_pkg.sv
// Shared types and helpers for the copro AXI4-Lite register bank.
package copro_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_AW,
    W_HAVE_W,
    W_RESP
  } wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } rd_state_e;

  function automatic int word_index(input logic [31:0] byte_addr);
    return int'(byte_addr >> 2);
  endfunction

  function automatic logic [31:0] merge_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] merged;
    merged = old_val;
    for (int k = 0; k < 4; k++) begin
      if (strb[k]) merged[8*k +: 8] = new_val[8*k +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/copro_axil_regs_if.sv
// AXI4-Lite bus bundle between the interconnect master and the copro register slave.
interface copro_axil_regs_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/copro_axil_regs.sv
// AXI4-Lite slave holding the copro register bank, exported with per-register write pulses.
// Define COPRO_AXIL_SLVERR_EN to answer out-of-range accesses with SLVERR instead of OKAY.
module copro_axil_regs
  import copro_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int NUM_REGS           = 4
) (
  input  logic                     s00_axi_aclk,
  input  logic                     s00_axi_areset,
  copro_axil_regs_if.slave         s00_axi,
  output logic [NUM_REGS*32-1:0]   reg_q,
  output logic [NUM_REGS-1:0]      reg_wr_pulse
);

`ifdef COPRO_AXIL_SLVERR_EN
  localparam logic [1:0] OOR_RESP = RESP_SLVERR;
`else
  localparam logic [1:0] OOR_RESP = RESP_OKAY;
`endif

  wr_state_e wr_state_q, wr_state_d;
  rd_state_e rd_state_q, rd_state_d;

  logic [NUM_REGS-1:0][C_S_AXI_DATA_WIDTH-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]           wr_pulse_q, wr_pulse_d;
  logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic [31:0]                   w_data_q, w_data_d;
  logic [3:0]                    w_strb_q, w_strb_d;
  logic [1:0]                    bresp_q, bresp_d;
  logic [31:0]                   rdata_q, rdata_d;
  logic [1:0]                    rresp_q, rresp_d;

  logic                          aw_hs, w_hs, ar_hs;
  logic                          commit;
  logic [C_S_AXI_ADDR_WIDTH-1:0] commit_addr;
  logic [31:0]                   commit_data;
  logic [3:0]                    commit_strb;
  int                            wr_idx, rd_idx;
  logic                          unused_prot;

  assign unused_prot = ^{s00_axi.awprot, s00_axi.arprot};

  // Readies are forced low while reset is held, independent of stale state.
  assign s00_axi.awready = !s00_axi_areset &&
                           (wr_state_q == W_IDLE || wr_state_q == W_HAVE_W);
  assign s00_axi.wready  = !s00_axi_areset &&
                           (wr_state_q == W_IDLE || wr_state_q == W_HAVE_AW);
  assign s00_axi.arready = !s00_axi_areset && (rd_state_q == R_IDLE);

  assign aw_hs = s00_axi.awvalid && s00_axi.awready;
  assign w_hs  = s00_axi.wvalid  && s00_axi.wready;
  assign ar_hs = s00_axi.arvalid && s00_axi.arready;

  assign s00_axi.bvalid = (wr_state_q == W_RESP);
  assign s00_axi.bresp  = bresp_q;
  assign s00_axi.rvalid = (rd_state_q == R_RESP);
  assign s00_axi.rdata  = rdata_q;
  assign s00_axi.rresp  = rresp_q;

  assign reg_q        = regs_q;
  assign reg_wr_pulse = wr_pulse_q;

  always_comb begin
    wr_state_d  = wr_state_q;
    aw_addr_d   = aw_addr_q;
    w_data_d    = w_data_q;
    w_strb_d    = w_strb_q;
    bresp_d     = bresp_q;
    regs_d      = regs_q;
    wr_pulse_d  = '0;
    commit      = 1'b0;
    commit_addr = aw_addr_q;
    commit_data = w_data_q;
    commit_strb = w_strb_q;
    wr_idx      = 0;

    unique case (wr_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit      = 1'b1;
          commit_addr = s00_axi.awaddr;
          commit_data = s00_axi.wdata;
          commit_strb = s00_axi.wstrb;
        end else if (aw_hs) begin
          aw_addr_d  = s00_axi.awaddr;
          wr_state_d = W_HAVE_AW;
        end else if (w_hs) begin
          w_data_d   = s00_axi.wdata;
          w_strb_d   = s00_axi.wstrb;
          wr_state_d = W_HAVE_W;
        end
      end
      W_HAVE_AW: begin
        if (w_hs) begin
          commit      = 1'b1;
          commit_data = s00_axi.wdata;
          commit_strb = s00_axi.wstrb;
        end
      end
      W_HAVE_W: begin
        if (aw_hs) begin
          commit      = 1'b1;
          commit_addr = s00_axi.awaddr;
        end
      end
      W_RESP: begin
        if (s00_axi.bready) wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase

    // The second handshake of the pair commits the register and arms the response.
    if (commit) begin
      wr_state_d = W_RESP;
      wr_idx     = word_index(32'(commit_addr));
      bresp_d    = (wr_idx < NUM_REGS) ? RESP_OKAY : OOR_RESP;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_idx == i) begin
          regs_d[i]     = merge_strb(regs_q[i], commit_data, commit_strb);
          wr_pulse_d[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    rd_idx     = word_index(32'(s00_axi.araddr));

    unique case (rd_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          rd_state_d = R_RESP;
          rdata_d    = '0;
          rresp_d    = (rd_idx < NUM_REGS) ? RESP_OKAY : OOR_RESP;
          for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == i) rdata_d = regs_q[i];
          end
        end
      end
      R_RESP: begin
        if (s00_axi.rready) rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      wr_state_q <= W_IDLE;
      rd_state_q <= R_IDLE;
      regs_q     <= '0;
      wr_pulse_q <= '0;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      regs_q     <= regs_d;
      wr_pulse_q <= wr_pulse_d;
      aw_addr_q  <= aw_addr_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      bresp_q    <= bresp_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

endmodule
